// File: rtl/vitals_frame_tx.sv
// Snapshots N_CH channel bytes on load and sends them to the host as one 8N1
// UART frame (LSB first): header 0xA5, ch0..ch(N_CH-1), then mod-256 checksum.
module vitals_frame_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int N_CH         = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [8*N_CH-1:0] ch_data,
  output logic              tx,
  output logic              busy,
  output logic              frame_done,
  output logic              dropped
);
  // state | meaning
  // IDLE  | line high, waiting for load
  // START | start bit (0) of the current byte
  // DATA  | 8 data bits of the current byte, LSB first
  // STOP  | stop bit (1); the checksum byte's stop bit ends the frame
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int             CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [4:0]     IDX_CHK  = 5'(N_CH + 1);
  localparam logic [7:0]     HEADER   = 8'hA5;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          bit_q, bit_d;
  logic [4:0]          idx_q, idx_d;
  logic [8*N_CH-1:0]   snap_q, snap_d;
  logic [7:0]          chk_q, chk_d;
  logic [7:0]          shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                drop_q, drop_d;
  logic [7:0]          sum_in;
  logic [7:0]          next_byte;
  logic [4:0]          idx_nxt;

  // Checksum is taken from the same bus value that gets latched, so it
  // always matches the snapshot.
  always_comb begin
    sum_in = '0;
    for (int i = 0; i < N_CH; i++) sum_in = sum_in + 8'(ch_data >> (8 * i));
  end

  always_comb begin
    idx_nxt   = idx_q + 5'd1;
    next_byte = chk_q;
    for (int i = 0; i < N_CH; i++)
      if (idx_nxt == 5'(i + 1)) next_byte = 8'(snap_q >> (8 * i));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    chk_d   = chk_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    drop_d  = load & busy_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          state_d = START;
          snap_d  = ch_data;
          chk_d   = sum_in;
          shift_d = HEADER;
          idx_d   = '0;
          cnt_d   = BIT_LAST;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          state_d = DATA;
          cnt_d   = BIT_LAST;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d = BIT_LAST;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          if (idx_q == IDX_CHK) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            tx_d    = 1'b1;
          end else begin
            // Next byte starts immediately: no idle gap inside a frame.
            state_d = START;
            idx_d   = idx_nxt;
            shift_d = next_byte;
            cnt_d   = BIT_LAST;
            tx_d    = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      chk_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      chk_q   <= chk_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign dropped    = drop_q;
endmodule

// File: tb/tb_vitals_frame_tx.sv
// Bench for vitals_frame_tx: frame-level reference model compared every cycle,
// a UART decoder on tx, and literal frame expectations for the named scenarios.
module tb_vitals_frame_tx;
  localparam int C     = 4;
  localparam int N     = 4;
  localparam int NB    = N + 2;
  localparam int NBITS = NB * 10;
  localparam int F     = NBITS * C;

  typedef logic [7:0] bq_t[$];

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           load = 1'b0;
  logic [8*N-1:0] ch_data = '0;
  logic           tx, busy, frame_done, dropped;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  vitals_frame_tx #(.CLKS_PER_BIT(C), .N_CH(N)) dut (
    .clk(clk), .rst(rst), .load(load), .ch_data(ch_data),
    .tx(tx), .busy(busy), .frame_done(frame_done), .dropped(dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bq_t frame_bytes(input logic [8*N-1:0] d);
    bq_t f;
    int  s = 0;
    f.push_back(8'hA5);
    for (int i = 0; i < N; i++) begin
      f.push_back(8'(d >> (8 * i)));
      s += int'(8'(d >> (8 * i)));
    end
    f.push_back(8'(s % 256));
    return f;
  endfunction

  // Reference model: a frame is a flat bit list; pos counts cycles since acceptance.
  int   pos = -1;
  bit   fbits[$];
  bq_t  mfb;
  bit   was_busy;
  logic exp_tx = 1'b1, exp_busy = 1'b0, exp_done = 1'b0, exp_drop = 1'b0;

  always @(posedge clk) begin
    exp_done = 1'b0;
    exp_drop = 1'b0;
    if (rst) begin
      pos = -1;
    end else begin
      was_busy = (pos >= 0);
      if (was_busy) begin
        pos++;
        if (pos == F) begin
          pos = -1;
          exp_done = 1'b1;
        end
      end
      if (load) begin
        if (was_busy) exp_drop = 1'b1;
        else begin
          mfb = frame_bytes(ch_data);
          fbits.delete();
          foreach (mfb[b]) begin
            fbits.push_back(1'b0);
            for (int k = 0; k < 8; k++) fbits.push_back(mfb[b][k]);
            fbits.push_back(1'b1);
          end
          pos = 0;
        end
      end
    end
    exp_busy = (pos >= 0);
    exp_tx   = (pos >= 0) ? fbits[pos / C] : 1'b1;
  end

  int done_cnt = 0, drop_cnt = 0, busy_run = 0, last_busy_len = 0, idle_run = 0;
  int gap_min = 1 << 20;
  int rx_t = -1;
  logic [7:0] rx_byte = '0;
  bq_t rx_q;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("tx", 32'(tx), 32'(exp_tx));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("frame_done", 32'(frame_done), 32'(exp_done));
      chk("dropped", 32'(dropped), 32'(exp_drop));
      if (frame_done === 1'b1) done_cnt++;
      if (dropped === 1'b1) drop_cnt++;
      if (busy === 1'b1) begin
        if (idle_run > 0 && idle_run < gap_min) gap_min = idle_run;
        idle_run = 0;
        busy_run++;
      end else begin
        if (busy_run > 0) last_busy_len = busy_run;
        busy_run = 0;
        idle_run++;
      end
      if (rst) rx_t = -1;
      else if (rx_t < 0) begin
        if (tx === 1'b0) rx_t = 0;
      end else begin
        rx_t++;
        if (rx_t % C == C / 2 && rx_t / C >= 1 && rx_t / C <= 8) rx_byte = {tx, rx_byte[7:1]};
        if (rx_t == 9 * C + C / 2) begin
          chk("rx_stop", 32'(tx), 32'd1);
          rx_q.push_back(rx_byte);
          rx_t = -1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [8*N-1:0] d);
    ch_data = d;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      tick();
      n++;
    end
    chk({name, "_timeout"}, 32'(n < 2000), 32'd1);
    repeat (3) tick();
  endtask

  task automatic expect_rx(input string name, input bq_t e);
    chk({name, "_nbytes"}, 32'(rx_q.size()), 32'(e.size()));
    for (int i = 0; i < e.size() && i < rx_q.size(); i++)
      chk({name, "_byte"}, 32'(rx_q[i]), 32'(e[i]));
  endtask

  initial begin
    logic [8*N-1:0] d;
    rst = 1'b1;
    repeat (3) tick();
    cmp_en = 1'b1;
    rst = 1'b0;
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(frame_done), 32'd0);
    chk("reset_drop", 32'(dropped), 32'd0);

    done_cnt = 0; drop_cnt = 0;
    repeat (1000) tick();
    chk("idle_done", 32'(done_cnt), 32'd0);
    chk("idle_drop", 32'(drop_cnt), 32'd0);
    chk("idle_tx", 32'(tx), 32'd1);

    rx_q.delete(); done_cnt = 0;
    pulse_load(32'h10256248);
    wait_idle("nominal");
    chk("nominal_busy_len", 32'(last_busy_len), 32'd240);
    chk("nominal_done", 32'(done_cnt), 32'd1);
    expect_rx("nominal", '{8'hA5, 8'h48, 8'h62, 8'h25, 8'h10, 8'hDF});

    rx_q.delete();
    pulse_load(32'hFFFFFFFF);
    wait_idle("wrap");
    expect_rx("wrap", '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC});

    rx_q.delete(); done_cnt = 0; drop_cnt = 0;
    pulse_load(32'h0A0B0C0D);
    ch_data = '0;
    repeat (48) tick();
    pulse_load('0);
    wait_idle("snap");
    repeat (300) tick();
    chk("snap_drop", 32'(drop_cnt), 32'd1);
    chk("snap_done", 32'(done_cnt), 32'd1);
    expect_rx("snap", '{8'hA5, 8'h0D, 8'h0C, 8'h0B, 8'h0A, 8'h2E});

    rx_q.delete(); done_cnt = 0; gap_min = 1 << 20;
    load = 1'b1;
    repeat (800) begin
      ch_data = $urandom;
      tick();
    end
    load = 1'b0;
    wait_idle("b2b");
    chk("b2b_gap", 32'(gap_min), 32'd1);
    chk("b2b_done", 32'(done_cnt), 32'd4);
    chk("b2b_nbytes", 32'(rx_q.size()), 32'(4 * NB));

    done_cnt = 0;
    pulse_load($urandom);
    repeat (99) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_tx", 32'(tx), 32'd1);
    chk("rstmid_busy", 32'(busy), 32'd0);
    repeat (20) tick();
    chk("rstmid_done", 32'(done_cnt), 32'd0);
    rx_q.delete();
    d = $urandom;
    pulse_load(d);
    wait_idle("rstmid_after");
    chk("rstmid_after_done", 32'(done_cnt), 32'd1);
    expect_rx("rstmid_after", frame_bytes(d));

    repeat (4000) begin
      load = ($urandom_range(0, 99) < 4);
      rst = ($urandom_range(0, 999) < 2);
      ch_data = $urandom;
      tick();
    end
    load = 1'b0;
    rst = 1'b0;
    wait_idle("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vitals_frame_tx.md
# vitals_frame_tx

Serial transmitter that reads a snapshot of the latched vital-sign channel registers and sends it to the host PC as one UART frame. The frame is a header byte, N_CH data bytes and a checksum, sent as 8N1, LSB first. The block sits downstream of the per-channel enable registers, which write the samples; this block is their reader and the transmit end of the monitor-to-host serial link.

## Interface
- CLKS_PER_BIT, default 868: clock cycles per UART bit (100 MHz / 115200). Legal range ≥ 2.
- N_CH, default 4: number of 8-bit channels per frame. Legal range 1..15.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- load  in  1  request to snapshot ch_data and send one frame. Sampled on every clk edge.
- ch_data  in  8*N_CH  channel snapshot. Channel i is bits [8i+7:8i]; ch0 is sent first.
- tx  out  1  UART serial line. Idle high.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle pulse when a frame completes.
- dropped  out  1  one-cycle pulse when a load is rejected because busy=1.

## Operation
- Reset values: tx=1, busy=0, frame_done=0, dropped=0, snapshot=0, checksum=0, state=IDLE.
- Frame byte order: 0xA5, ch0 … ch(N_CH-1), CHK.
  - CHK = (ch0 + … + ch(N_CH-1)) mod 256.
  - The header is excluded from the sum.
  - Sum wraps modulo 256; carries are discarded.
- Byte format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit is CLKS_PER_BIT cycles.
- FSM states:
  - IDLE, START, DATA, STOP.
  - A byte index 0..N_CH+1 selects header, data or CHK.
  - IDLE→START when load=1.
  - START→DATA after CLKS_PER_BIT cycles.
  - DATA→STOP after 8 bits.
  - STOP→START with the next byte index, or STOP→IDLE after the last byte (CHK).
  - No idle gap between bytes inside a frame.
- Load acceptance:
  - load=1 with busy=0: the whole ch_data bus is latched atomically on that edge. CHK is computed from the latched copy. Later changes to ch_data do not affect the frame in flight.
  - load=1 with busy=1: ignored, and dropped pulses for one cycle. The frame in flight is unaffected.
- tx is driven from a flop; it is glitch-free.
- rst=1 mid-frame: on the next edge the block returns to the reset values. The partial frame is abandoned and no frame_done is produced.

## Timing
- Load accepted at edge E:
  - busy=1 and tx=0 (start bit) from the cycle following E.
  - The start bit lasts CLKS_PER_BIT cycles.
- busy stays high for exactly (N_CH+2)×10×CLKS_PER_BIT cycles.
- At the edge ending the last stop bit:
  - busy→0 and frame_done→1 for one cycle; tx stays 1.
  - A load sampled during that frame_done cycle is accepted, because busy=0.
  - The minimum gap between back-to-back frames is therefore 1 idle-high cycle.
- dropped is asserted in the cycle after the rejected load edge.
- frame_done is never asserted in the same cycle as busy=1.

## Test plan
Use CLKS_PER_BIT=4 and N_CH=4 throughout.
- **Nominal frame:** ch_data = 0x10_25_62_48 (ch0=0x48), single load pulse. Required:
  - tx bytes A5 48 62 25 10 DF.
  - busy high for exactly 240 cycles.
  - One frame_done pulse.
  - Start and stop bits each 4 cycles wide.
- **Checksum wrap:** ch_data = 0xFFFFFFFF. Required: data bytes FF FF FF FF, then CHK=0xFC.
- **Snapshot isolation and drop:** load, then change ch_data to 0 and pulse load at cycle 50. Required:
  - The frame still carries the original bytes.
  - dropped pulses once, one cycle after the load.
  - No second frame is sent.
- **Back-to-back:** hold load=1 continuously. Required:
  - Frames repeat with exactly one tx=1 cycle between the end of a stop bit and the next start bit.
  - dropped pulses every busy cycle.
- **Reset mid-frame:** assert rst for 1 cycle at cycle 100 of a frame. Required:
  - Next cycle tx=1 and busy=0.
  - No frame_done.
  - A subsequent load produces a complete, correct frame.
- **Idle:** with no load for 1000 cycles after reset, tx=1 and all pulse outputs stay 0.
